herloa_pipe_adder: RTL and testbench

Pipelined, runtime-configurable HERLOA approximate adder with valid/ready flow control and a built-in error monitor. The approximate lower-part width is selected per operation, from exact (0) up to KMAX. A carry-out is produced. Every result is checked against an exact sum computed in parallel, and saturating error statistics are accumulated. The block sits in the approximate-arithmetic datapath and serves as the characterisation harness for the HERLOA family.

---
 rtl/herloa_pipe_adder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_herloa_pipe_adder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/herloa_pipe_adder.sv
// -----------------------------------------------------------------------------
// herloa_pipe_adder
//
// Pipelined HERLOA approximate adder with a per-beat approximate width, a
// valid/ready handshake and an error monitor that compares every result with
// the exact sum and accumulates saturating statistics.
//
// Register ranks:
//   s1  : captured operands A, B and the clamped width k.
//   s2  : approximate low part, carry-in g, lower halves of the approximate
//         and exact sums, upper operand halves.
//   out : S, COUT, ED (registered outputs), out_valid.
// A beat accepted at edge t is visible after edge t+2. All ranks share one
// enable, so the whole pipe freezes while a result waits for out_ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready = pipe enable)
//   A, B, K_SEL       operands and requested approximate width (clamped)
//   out_valid/out_ready output handshake
//   S, COUT, ED       approximate sum, carry-out, |exact - approximate|
//   stat_clr          synchronous clear of statistics (wins over a transfer)
//   err_cnt, ed_sum   saturating count of erroneous results / sum of ED
//   ed_max            largest ED seen
// -----------------------------------------------------------------------------
module herloa_pipe_adder #(
    parameter int N    = 16,
    parameter int KMAX = 8,
    parameter int CW   = 16,
    parameter int SW   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               A,
    input  logic [N-1:0]               B,
    input  logic [$clog2(KMAX+1)-1:0]  K_SEL,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               S,
    output logic                       COUT,
    output logic [N:0]                 ED,
    input  logic                       stat_clr,
    output logic [CW-1:0]              err_cnt,
    output logic [SW-1:0]              ed_sum,
    output logic [N:0]                 ed_max
);

    localparam int KW   = $clog2(KMAX + 1);
    localparam int L    = N / 2;
    localparam int H    = N - L;
    // Accumulator scratch width: one bit wider than both ed_sum and ED.
    localparam int SUMW = ((SW > N + 1) ? SW : N + 1) + 1;
    localparam logic [KW-1:0] KMAX_K = KW'(KMAX);

    // Unsigned absolute difference of two (N+1)-bit values.
    function automatic logic [N:0] abs_diff(input logic [N:0] x, input logic [N:0] y);
        if (x >= y) begin
            return x - y;
        end else begin
            return y - x;
        end
    endfunction

    // ------------------------------------------------------------------ enable
    logic en_s;
    logic out_valid_q;

    // Reset is folded in so in_ready reads 1 throughout reset.
    assign en_s     = rst | ~out_valid_q | out_ready;
    assign in_ready = en_s;

    // ------------------------------------------------------------------ stage 1
    logic          v1_q;
    logic [N-1:0]  a1_q;
    logic [N-1:0]  b1_q;
    logic [KW-1:0] k1_q;
    logic [KW-1:0] k_clamp_s;

    assign k_clamp_s = (K_SEL > KMAX_K) ? KMAX_K : K_SEL;

    // Operand capture rank.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            a1_q <= {N{1'b0}};
            b1_q <= {N{1'b0}};
            k1_q <= {KW{1'b0}};
        end else if (en_s) begin
            v1_q <= in_valid;
            a1_q <= A;
            b1_q <= B;
            k1_q <= k_clamp_s;
        end
    end

    // low_s marks bits below k-1, top_s marks bit k-1 (both empty for k = 0).
    logic [N-1:0] low_s;
    logic [N-1:0] top_s;

    // Decode the per-beat approximate width into bit masks.
    always_comb begin
        low_s = {N{1'b0}};
        top_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (i < int'(k1_q) - 1) begin
                low_s[i] = 1'b1;
            end else if (i == int'(k1_q) - 1) begin
                top_s[i] = 1'b1;
            end else begin
                low_s[i] = 1'b0;
            end
        end
    end

    logic [N-1:0] and_s;
    logic [N-1:0] prev_and_s;
    logic         g_s;
    logic [N-1:0] lo_s;
    logic [N-1:0] mask_s;
    logic [N-1:0] ua_s;
    logic [N-1:0] ub_s;
    logic [N-1:0] cv_s;
    logic [L:0]   asum_lo_s;
    logic [L:0]   esum_lo_s;

    assign and_s      = a1_q & b1_q;
    // Generate of the neighbouring lower bit; bit 0 has no neighbour, which
    // makes the extra term vanish for k = 1.
    assign prev_and_s = {and_s[N-2:0], 1'b0};
    assign g_s        = |(and_s & top_s);
    assign lo_s       = (low_s & (a1_q | b1_q | {N{g_s}}))
                      | (top_s & ((a1_q ^ b1_q) | prev_and_s));
    // Upper operands with the approximate region cleared; g enters at bit k.
    assign mask_s     = low_s | top_s;
    assign ua_s       = a1_q & ~mask_s;
    assign ub_s       = b1_q & ~mask_s;
    assign cv_s       = g_s ? (top_s << 1) : {N{1'b0}};
    assign asum_lo_s  = {1'b0, ua_s[L-1:0]} + {1'b0, ub_s[L-1:0]} + {1'b0, cv_s[L-1:0]};
    assign esum_lo_s  = {1'b0, a1_q[L-1:0]} + {1'b0, b1_q[L-1:0]};

    // ------------------------------------------------------------------ stage 2
    logic         v2_q;
    logic [N-1:0] lo2_q;
    logic [H-1:0] ua_hi_q;
    logic [H-1:0] ub_hi_q;
    logic [H-1:0] cv_hi_q;
    logic [L:0]   asum_lo_q;
    logic [H-1:0] ea_hi_q;
    logic [H-1:0] eb_hi_q;
    logic [L:0]   esum_lo_q;

    // Partial-sum rank.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q      <= 1'b0;
            lo2_q     <= {N{1'b0}};
            ua_hi_q   <= {H{1'b0}};
            ub_hi_q   <= {H{1'b0}};
            cv_hi_q   <= {H{1'b0}};
            asum_lo_q <= {(L+1){1'b0}};
            ea_hi_q   <= {H{1'b0}};
            eb_hi_q   <= {H{1'b0}};
            esum_lo_q <= {(L+1){1'b0}};
        end else if (en_s) begin
            v2_q      <= v1_q;
            lo2_q     <= lo_s;
            ua_hi_q   <= ua_s[N-1:L];
            ub_hi_q   <= ub_s[N-1:L];
            cv_hi_q   <= cv_s[N-1:L];
            asum_lo_q <= asum_lo_s;
            ea_hi_q   <= a1_q[N-1:L];
            eb_hi_q   <= b1_q[N-1:L];
            esum_lo_q <= esum_lo_s;
        end
    end

    logic [H:0] asum_hi_s;
    logic [H:0] esum_hi_s;
    logic [N:0] approx_s;
    logic [N:0] exact_s;
    logic [N:0] ed_s;

    assign asum_hi_s = {1'b0, ua_hi_q} + {1'b0, ub_hi_q} + {1'b0, cv_hi_q}
                     + {{H{1'b0}}, asum_lo_q[L]};
    assign esum_hi_s = {1'b0, ea_hi_q} + {1'b0, eb_hi_q} + {{H{1'b0}}, esum_lo_q[L]};
    // The upper sum is zero below bit k, so OR merges in the approximate part.
    assign approx_s  = {asum_hi_s, asum_lo_q[L-1:0]} | {1'b0, lo2_q};
    assign exact_s   = {esum_hi_s, esum_lo_q[L-1:0]};
    assign ed_s      = abs_diff(exact_s, approx_s);

    // ------------------------------------------------------------------ output
    logic [N-1:0] s_q;
    logic         cout_q;
    logic [N:0]   ed_q;

    // Result rank; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= {N{1'b0}};
            cout_q      <= 1'b0;
            ed_q        <= {(N+1){1'b0}};
        end else if (en_s) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                s_q    <= approx_s[N-1:0];
                cout_q <= approx_s[N];
                ed_q   <= ed_s;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign COUT      = cout_q;
    assign ED        = ed_q;

    // ------------------------------------------------------------------ stats
    logic            xfer_s;
    logic [CW-1:0]   err_cnt_q, err_cnt_d;
    logic [SW-1:0]   ed_sum_q,  ed_sum_d;
    logic [N:0]      ed_max_q,  ed_max_d;
    logic [SUMW-1:0] sum_ext_s;

    assign xfer_s    = out_valid_q & out_ready;
    assign sum_ext_s = SUMW'(ed_sum_q) + SUMW'(ed_q);

    // Statistics next state: clear has priority over a transfer update.
    always_comb begin
        err_cnt_d = err_cnt_q;
        ed_sum_d  = ed_sum_q;
        ed_max_d  = ed_max_q;
        if (stat_clr) begin
            err_cnt_d = {CW{1'b0}};
            ed_sum_d  = {SW{1'b0}};
            ed_max_d  = {(N+1){1'b0}};
        end else if (xfer_s) begin
            if ((ed_q != {(N+1){1'b0}}) && (err_cnt_q != {CW{1'b1}})) begin
                err_cnt_d = err_cnt_q + CW'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (|sum_ext_s[SUMW-1:SW]) begin
                ed_sum_d = {SW{1'b1}};
            end else begin
                ed_sum_d = sum_ext_s[SW-1:0];
            end
            if (ed_q > ed_max_q) begin
                ed_max_d = ed_q;
            end else begin
                ed_max_d = ed_max_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= {CW{1'b0}};
            ed_sum_q  <= {SW{1'b0}};
            ed_max_q  <= {(N+1){1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
            ed_sum_q  <= ed_sum_d;
            ed_max_q  <= ed_max_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign ed_sum  = ed_sum_q;
    assign ed_max  = ed_max_q;

endmodule

// File: tb/tb_herloa_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_herloa_pipe_adder
//
// Drives directed and randomized beats into herloa_pipe_adder and compares
// every result and the statistics against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_herloa_pipe_adder;

    localparam int N    = 16;
    localparam int KMAX = 8;
    localparam int CW   = 4;
    localparam int SW   = 12;
    localparam int KW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic [KW-1:0] K_SEL;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  S;
    logic          COUT;
    logic [N:0]    ED;
    logic          stat_clr;
    logic [CW-1:0] err_cnt;
    logic [SW-1:0] ed_sum;
    logic [N:0]    ed_max;

    always #5 clk = ~clk;

    herloa_pipe_adder #(.N(N), .KMAX(KMAX), .CW(CW), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .K_SEL(K_SEL),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .COUT(COUT), .ED(ED),
        .stat_clr(stat_clr),
        .err_cnt(err_cnt), .ed_sum(ed_sum), .ed_max(ed_max)
    );

    typedef struct {
        logic [N-1:0] s;
        logic         cout;
        logic [N:0]   ed;
        int           acc_cyc;
        int           acc_stall;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         head;
    logic [N-1:0] got_s[$];
    int           pop_cyc[$];
    logic [N-1:0] last_s;
    logic         last_cout;
    logic [N:0]   last_ed;
    int           cyc       = 0;
    int           stall_cnt = 0;
    bit           head_new  = 1'b1;
    int           rdy_mode  = 0;
    int           n_checks  = 0;
    int           n_fail    = 0;
    longint       m_cnt     = 0;
    longint       m_sum     = 0;
    logic [N:0]   m_max     = '0;

    // Single comparison point: counts and reports a mismatch.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: HERLOA rule written directly as integer arithmetic.
    function automatic exp_t ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input int ksel);
        exp_t       e;
        int         k;
        logic       g;
        logic [N-1:0] lo;
        logic [N:0] ex;
        logic [N:0] ap;
        logic [N:0] up;
        k  = (ksel > KMAX) ? KMAX : ksel;
        ex = {1'b0, a} + {1'b0, b};
        if (k == 0) begin
            ap = ex;
        end else begin
            g  = a[k-1] & b[k-1];
            lo = '0;
            for (int i = 0; i < k - 1; i++) lo[i] = a[i] | b[i] | g;
            lo[k-1] = a[k-1] ^ b[k-1];
            if (k > 1) lo[k-1] = lo[k-1] | (a[k-2] & b[k-2]);
            up = ({1'b0, a} >> k) + ({1'b0, b} >> k) + {{N{1'b0}}, g};
            ap = (up << k) | {1'b0, lo};
        end
        e.s         = ap[N-1:0];
        e.cout      = ap[N];
        e.ed        = (ex >= ap) ? (ex - ap) : (ap - ex);
        e.acc_cyc   = 0;
        e.acc_stall = 0;
        return e;
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0; m_sum = 0; m_max = '0;
            head_new = 1'b1;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            check("err_cnt", err_cnt, m_cnt);
            check("ed_sum", ed_sum, m_sum);
            check("ed_max", ed_max, m_max);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    head = exp_q[0];
                    if (head_new) begin
                        if (head.acc_stall == stall_cnt)
                            check("latency", cyc - head.acc_cyc, 3);
                        head_new = 1'b0;
                    end
                    check("S", S, head.s);
                    check("COUT", COUT, head.cout);
                    check("ED", ED, head.ed);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        last_s = S; last_cout = COUT; last_ed = ED;
                        got_s.push_back(S);
                        pop_cyc.push_back(cyc);
                        head_new = 1'b1;
                        if (!stat_clr) begin
                            if (head.ed != 0 && m_cnt < (2**CW - 1)) m_cnt++;
                            m_sum = m_sum + head.ed;
                            if (m_sum > (2**SW - 1)) m_sum = 2**SW - 1;
                            if (head.ed > m_max) m_max = head.ed;
                        end
                    end
                end
                if (!out_ready) stall_cnt++;
            end
            if (stat_clr) begin
                m_cnt = 0; m_sum = 0; m_max = '0;
            end
            if (in_valid && in_ready) begin
                head           = ref_model(A, B, int'(K_SEL));
                head.acc_cyc   = cyc;
                head.acc_stall = stall_cnt;
                exp_q.push_back(head);
            end
        end
    end

    // Consumer ready generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input int k);
        bit ok;
        ok       = 1'b0;
        A        = a;
        B        = b;
        K_SEL    = k[KW-1:0];
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            idle(1);
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; K_SEL = '0; stat_clr = 1'b0;
        idle(1);
        check("rst_in_ready", in_ready, 1);
        idle(1);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_ed_sum", ed_sum, 0);
        check("rst_ed_max", ed_max, 0);
        check("rst_in_ready2", in_ready, 1);

        // Basic approximate add.
        send(16'h00FF, 16'h00FF, 6);
        drain();
        check("t2_S", last_s, 16'h01FF);
        check("t2_COUT", last_cout, 0);
        check("t2_ED", last_ed, 1);
        check("t2_err_cnt", err_cnt, 1);
        check("t2_ed_sum", ed_sum, 1);
        check("t2_ed_max", ed_max, 1);

        // Back-to-back beats with a K_SEL change.
        p0 = got_s.size();
        send(16'hFFFF, 16'h0001, 6);
        send(16'hFFFF, 16'h0001, 0);
        drain();
        check("t3_S0", got_s[p0], 16'hFFFF);
        check("t3_S1", got_s[p0+1], 16'h0000);
        check("t3_COUT1", last_cout, 1);
        check("t3_ED1", last_ed, 0);
        check("t3_consecutive", pop_cyc[p0+1] - pop_cyc[p0], 1);
        check("t3_err_cnt", err_cnt, 2);

        // Stall with out_ready held low for 5 cycles.
        p0 = got_s.size();
        fork
            begin
                for (int i = 0; i < 4; i++) send(N'(i), N'(i), 0);
            end
            begin
                rdy_mode = 2;
                seen = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                    idle(1);
                end
                check("t4_valid_seen", seen, 1);
                for (int t = 0; t < 5; t++) begin
                    check("t4_in_ready_low", in_ready, 0);
                    check("t4_S_held", S, 16'h0000);
                    idle(1);
                end
                rdy_mode = 0;
            end
        join
        drain();
        check("t4_count", got_s.size() - p0, 4);
        for (int i = 0; i < 4; i++) check("t4_order", got_s[p0+i], N'(2 * i));

        // K_SEL above KMAX is clamped.
        send(16'h00FF, 16'h0001, 15);
        drain();
        check("t5_S", last_s, 16'h00FF);
        check("t5_COUT", last_cout, 0);
        check("t5_ED", last_ed, 1);

        // Saturation of err_cnt.
        for (int i = 0; i < 20; i++) send(16'h00FF, 16'h00FF, 6);
        drain();
        check("t6_err_sat", err_cnt, 15);
        check("t6_ed_sum", ed_sum, 23);
        check("t6_ed_max", ed_max, 1);

        // stat_clr coincident with a transfer.
        send(16'h00FF, 16'h00FF, 6);
        idle(2);
        check("t6_clr_valid", out_valid, 1);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        check("t6_clr_err_cnt", err_cnt, 0);
        check("t6_clr_ed_sum", ed_sum, 0);
        check("t6_clr_ed_max", ed_max, 0);

        // Reset with beats in flight.
        send(16'h00FF, 16'h00FF, 6);
        drain();
        send(16'h1234, 16'h0F0F, 3);
        send(16'h5555, 16'hAAAB, 7);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t7_out_valid", out_valid, 0);
        check("t7_err_cnt", err_cnt, 0);
        check("t7_ed_sum", ed_sum, 0);
        idle(4);
        check("t7_discarded", out_valid, 0);

        // Randomized traffic with random back-pressure and occasional clears.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            stat_clr = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(N'($urandom), N'($urandom), $urandom_range(0, 15));
        end
        stat_clr = 1'b0;
        rdy_mode = 0;
        drain();
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
